// File: rtl/state_sequencer_pkg.sv
// Shared state/opcode definitions for the CPU controller sequencer and decoder.
// state[11:4] is a one-hot group select, state[3:0] the step index within it.
package state_sequencer_pkg;

    localparam int GRP_R    = 4;
    localparam int GRP_F    = 5;
    localparam int GRP_D    = 6;
    localparam int GRP_MOV  = 7;
    localparam int GRP_LD   = 8;
    localparam int GRP_ST   = 9;
    localparam int GRP_HALT = 10;

    typedef enum logic [11:0] {
        state_R0    = 12'h010,
        state_F0    = 12'h020,
        state_F1    = 12'h021,
        state_F2    = 12'h022,
        state_D0    = 12'h040,
        state_MOV0  = 12'h080,
        state_LD0   = 12'h100,
        state_LD1   = 12'h101,
        state_LD2   = 12'h102,
        state_LD3   = 12'h103,
        state_LD4   = 12'h104,
        state_ST0   = 12'h200,
        state_ST1   = 12'h201,
        state_ST2   = 12'h202,
        state_ST3   = 12'h203,
        state_ST4   = 12'h204,
        state_HALT0 = 12'h400
    } sq_state_t;

    localparam logic [3:0] opNOP  = 4'h0;
    localparam logic [3:0] opMOV  = 4'h1;
    localparam logic [3:0] opLD   = 4'h2;
    localparam logic [3:0] opST   = 4'h3;
    localparam logic [3:0] opHALT = 4'hF;

    // Steps within a group are consecutive, so advancing is a step-index increment.
    function automatic sq_state_t next_step(input sq_state_t s);
        return sq_state_t'(s + 12'd1);
    endfunction

endpackage

// File: rtl/state_sequencer_retire_counter.sv
// Wrapping retired-instruction counter with synchronous clear.
module retire_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/state_sequencer.sv
// Control-state sequencer: fetch/decode/execute walk driven by decoder feedback
// and monitor run/step commands.
module state_sequencer
    import state_sequencer_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter bit AUTO_START = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       I,
    input  logic             end_sq,
    input  logic             pause_cc,
    input  logic             start,
    input  logic             step_mode,
    output logic [11:0]      state,
    output logic             halted,
    output logic             waiting,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_cnt
);

    sq_state_t  cur_state;
    logic [3:0] op;
    logic       retire;
    logic       unused_operand;

    assign op             = I[7:4];
    assign unused_operand = ^I[3:0];

    // A NOP retires directly from D0 without any decoder end_sq.
    assign retire = end_sq || (cur_state == state_D0 && op == opNOP);

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= state_R0;
            illegal   <= 1'b0;
        end else if (end_sq) begin
            cur_state <= step_mode ? state_R0 : state_F0;
        end else begin
            case (cur_state)
                state_R0:
                    if (start || AUTO_START) cur_state <= state_F0;
                state_D0:
                    case (op)
                        opNOP:   cur_state <= step_mode ? state_R0 : state_F0;
                        opMOV:   cur_state <= state_MOV0;
                        opLD:    cur_state <= state_LD0;
                        opST:    cur_state <= state_ST0;
                        opHALT:  cur_state <= state_HALT0;
                        default: begin
                            cur_state <= state_HALT0;
                            illegal   <= 1'b1;
                        end
                    endcase
                // Terminal steps leave only through end_sq; HALT0 only through reset.
                state_MOV0, state_LD4, state_ST4, state_HALT0:
                    cur_state <= cur_state;
                state_F2:
                    if (!pause_cc) cur_state <= state_D0;
                state_F0, state_F1,
                state_LD0, state_LD1, state_LD2, state_LD3,
                state_ST0, state_ST1, state_ST2, state_ST3:
                    if (!pause_cc) cur_state <= next_step(cur_state);
                default:
                    cur_state <= state_R0;
            endcase
        end
    end

    assign state   = cur_state;
    assign halted  = (cur_state == state_HALT0);
    assign waiting = (cur_state == state_R0);

    retire_counter #(.CNT_W(CNT_W)) u_retire (
        .clk (clk),
        .clr (reset),
        .inc (retire),
        .cnt (instr_cnt)
    );

endmodule

// File: tb/tb_state_sequencer.sv
// Directed-vector bench for state_sequencer, run with a 4-bit retire counter.
module tb_state_sequencer;

    localparam int CNT_W = 4;

    localparam logic [11:0] S_R0    = 12'h010;
    localparam logic [11:0] S_F0    = 12'h020;
    localparam logic [11:0] S_F1    = 12'h021;
    localparam logic [11:0] S_F2    = 12'h022;
    localparam logic [11:0] S_D0    = 12'h040;
    localparam logic [11:0] S_MOV0  = 12'h080;
    localparam logic [11:0] S_LD0   = 12'h100;
    localparam logic [11:0] S_LD3   = 12'h103;
    localparam logic [11:0] S_ST0   = 12'h200;
    localparam logic [11:0] S_ST2   = 12'h202;
    localparam logic [11:0] S_ST3   = 12'h203;
    localparam logic [11:0] S_ST4   = 12'h204;
    localparam logic [11:0] S_HALT0 = 12'h400;

    logic             clk;
    logic             reset;
    logic [7:0]       I;
    logic             end_sq;
    logic             pause_cc;
    logic             start;
    logic             step_mode;
    logic [11:0]      state;
    logic             halted;
    logic             waiting;
    logic             illegal;
    logic [CNT_W-1:0] instr_cnt;

    int vectors;
    int miscompares;

    state_sequencer #(.CNT_W(CNT_W), .AUTO_START(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .I         (I),
        .end_sq    (end_sq),
        .pause_cc  (pause_cc),
        .start     (start),
        .step_mode (step_mode),
        .state     (state),
        .halted    (halted),
        .waiting   (waiting),
        .illegal   (illegal),
        .instr_cnt (instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; end_sq = 1'b0; pause_cc = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (state !== S_R0) begin
            miscompares++; $display("FAIL reset_state: got %h expected %h", state, S_R0);
        end
        vectors++;
        if ({waiting, halted, illegal} !== 3'b100) begin
            miscompares++; $display("FAIL reset_flags: got %b expected 100", {waiting, halted, illegal});
        end
        vectors++;
        if (instr_cnt !== 4'd0) begin
            miscompares++; $display("FAIL reset_cnt: got %0d expected 0", instr_cnt);
        end
        repeat (3) tick();
        vectors++;
        if (state !== S_R0) begin
            miscompares++; $display("FAIL idle_without_start: got %h expected %h", state, S_R0);
        end
    endtask

    task automatic test_mov();
        logic [11:0] seq [0:4];
        seq = '{S_F0, S_F1, S_F2, S_D0, S_MOV0};
        do_reset();
        step_mode = 1'b0;
        I = 8'h16;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            vectors++;
            if (state !== seq[k]) begin
                miscompares++; $display("FAIL mov_seq[%0d]: got %h expected %h", k, state, seq[k]);
            end
        end
        // MOV0 holds until the decoder signals end_sq.
        tick();
        vectors++;
        if (state !== S_MOV0) begin
            miscompares++; $display("FAIL mov_hold_terminal: got %h expected %h", state, S_MOV0);
        end
        end_sq = 1'b1;
        tick();
        end_sq = 1'b0;
        vectors++;
        if (state !== S_F0 || instr_cnt !== 4'd1) begin
            miscompares++; $display("FAIL mov_retire: got %h/%0d expected %h/1", state, instr_cnt, S_F0);
        end
    endtask

    task automatic test_ld_step();
        do_reset();
        step_mode = 1'b1;
        I = 8'h21;
        pulse_start();
        tick(); tick(); tick();
        vectors++;
        if (state !== S_D0) begin
            miscompares++; $display("FAIL ld_d0: got %h expected %h", state, S_D0);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if (state !== S_LD0 + 12'(k)) begin
                miscompares++; $display("FAIL ld_seq[%0d]: got %h expected %h", k, state, S_LD0 + 12'(k));
            end
        end
        end_sq = 1'b1;
        tick();
        end_sq = 1'b0;
        vectors++;
        if (state !== S_R0 || waiting !== 1'b1 || instr_cnt !== 4'd1) begin
            miscompares++; $display("FAIL ld_park: got %h/%b/%0d expected %h/1/1", state, waiting, instr_cnt, S_R0);
        end
        repeat (3) tick();
        vectors++;
        if (state !== S_R0 || instr_cnt !== 4'd1) begin
            miscompares++; $display("FAIL ld_stay_parked: got %h/%0d expected %h/1", state, instr_cnt, S_R0);
        end
        pulse_start();
        vectors++;
        if (state !== S_F0) begin
            miscompares++; $display("FAIL ld_restart: got %h expected %h", state, S_F0);
        end
        step_mode = 1'b0;
    endtask

    task automatic test_st_pause();
        do_reset();
        I = 8'h3C;
        // pause_cc in F0 holds the fetch.
        pulse_start();
        pause_cc = 1'b1;
        tick();
        pause_cc = 1'b0;
        vectors++;
        if (state !== S_F0) begin
            miscompares++; $display("FAIL st_pause_f0: got %h expected %h", state, S_F0);
        end
        repeat (6) tick();
        vectors++;
        if (state !== S_ST2) begin
            miscompares++; $display("FAIL st_reach_st2: got %h expected %h", state, S_ST2);
        end
        pause_cc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            vectors++;
            if (state !== S_ST2 || instr_cnt !== 4'd0) begin
                miscompares++; $display("FAIL st_hold[%0d]: got %h/%0d expected %h/0", k, state, instr_cnt, S_ST2);
            end
        end
        pause_cc = 1'b0;
        tick();
        vectors++;
        if (state !== S_ST3) begin
            miscompares++; $display("FAIL st_st3: got %h expected %h", state, S_ST3);
        end
        tick();
        vectors++;
        if (state !== S_ST4) begin
            miscompares++; $display("FAIL st_st4: got %h expected %h", state, S_ST4);
        end
        end_sq = 1'b1;
        tick();
        end_sq = 1'b0;
        vectors++;
        if (state !== S_F0 || instr_cnt !== 4'd1) begin
            miscompares++; $display("FAIL st_retire: got %h/%0d expected %h/1", state, instr_cnt, S_F0);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        I = 8'h5A;
        pulse_start();
        repeat (4) tick();
        vectors++;
        if (state !== S_HALT0 || {halted, illegal, waiting} !== 3'b110) begin
            miscompares++; $display("FAIL illegal_halt: got %h/%b expected %h/110", state, {halted, illegal, waiting}, S_HALT0);
        end
        pulse_start();
        pause_cc = 1'b1;
        tick();
        pause_cc = 1'b0;
        tick();
        vectors++;
        if (state !== S_HALT0 || illegal !== 1'b1 || instr_cnt !== 4'd0) begin
            miscompares++; $display("FAIL illegal_sticky: got %h/%b/%0d expected %h/1/0", state, illegal, instr_cnt, S_HALT0);
        end
        do_reset();
        vectors++;
        if (state !== S_R0 || {halted, illegal} !== 2'b00 || instr_cnt !== 4'd0) begin
            miscompares++; $display("FAIL illegal_clear: got %h/%b/%0d expected %h/00/0", state, {halted, illegal}, instr_cnt, S_R0);
        end
    endtask

    task automatic test_halt_op();
        do_reset();
        I = 8'hF0;
        pulse_start();
        repeat (4) tick();
        vectors++;
        if (state !== S_HALT0 || {halted, illegal} !== 2'b10) begin
            miscompares++; $display("FAIL halt_op: got %h/%b expected %h/10", state, {halted, illegal}, S_HALT0);
        end
    endtask

    task automatic test_nop_wrap();
        logic [CNT_W-1:0] exp_cnt;
        do_reset();
        I = 8'h00;
        exp_cnt = '0;
        pulse_start();
        for (int n = 1; n <= 16; n++) begin
            repeat (3) tick();
            vectors++;
            if (state !== S_D0) begin
                miscompares++; $display("FAIL nop_d0[%0d]: got %h expected %h", n, state, S_D0);
            end
            tick();
            exp_cnt = exp_cnt + 1'b1;
            vectors++;
            if (state !== S_F0 || instr_cnt !== exp_cnt) begin
                miscompares++; $display("FAIL nop_retire[%0d]: got %h/%0d expected %h/%0d", n, state, instr_cnt, S_F0, exp_cnt);
            end
        end
        vectors++;
        if (instr_cnt !== 4'd0) begin
            miscompares++; $display("FAIL nop_wrap: got %0d expected 0", instr_cnt);
        end
    endtask

    task automatic test_reset_mid_ld();
        do_reset();
        I = 8'h21;
        pulse_start();
        repeat (7) tick();
        vectors++;
        if (state !== S_LD3) begin
            miscompares++; $display("FAIL abort_reach_ld3: got %h expected %h", state, S_LD3);
        end
        // Reset wins over a simultaneous end_sq: no retire is counted.
        reset = 1'b1;
        end_sq = 1'b1;
        tick();
        reset = 1'b0;
        end_sq = 1'b0;
        vectors++;
        if (state !== S_R0 || instr_cnt !== 4'd0) begin
            miscompares++; $display("FAIL abort_ld3: got %h/%0d expected %h/0", state, instr_cnt, S_R0);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1; I = 8'h00; end_sq = 1'b0; pause_cc = 1'b0;
        start = 1'b0; step_mode = 1'b0;
        #1;
        test_reset();
        test_mov();
        test_ld_step();
        test_st_pause();
        test_illegal();
        test_halt_op();
        test_nop_wrap();
        test_reset_mid_ld();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/state_sequencer.md
Name: state_sequencer

Overview:
- Sequences the CPU controller: holds the 12-bit control state that drives the combinational instruction decoder.
- Walks the fetch, decode and execute steps for the MOV, LD, ST, NOP and HALT instructions.
- Advances on the decoder's end_sq and pause_cc feedback; accepts run or single-step commands from the monitor.
- Sits between the monitor control interface and the instruction decoder in the controller.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- AUTO_START, 0, 1 = leave state R without waiting for start.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous active-high reset.
- I  input  8  current instruction register contents; I[7:4] is the opcode.
- end_sq  input  1  from decoder: last step of the current instruction.
- pause_cc  input  1  from decoder: hold the current state.
- start  input  1  monitor: one-cycle pulse to leave state R.
- step_mode  input  1  monitor: 1 = park in R after each retired instruction.
- state  output  12  current sequencer state, fed to the decoder.
- halted  output  1  state == HALT.
- waiting  output  1  state == R.
- illegal  output  1  sticky flag: an undefined opcode was decoded.
- instr_cnt  output  CNT_W  count of retired instructions.

Behaviour:
- Reset is synchronous, active-high, one clock, one reset port; it overrides everything.
  - On reset: state=R, illegal=0, instr_cnt=0.
  - Reset asserted mid-instruction aborts the instruction immediately; no partial retire is counted.
- State encoding: state[11:4] is a one-hot group and state[3:0] is the step index.
  - Groups: bit4 R, bit5 F, bit6 D, bit7 MOV, bit8 LD, bit9 ST, bit10 HALT; bit11 is reserved and always 0.
  - Defined states: R0, F0-F2, D0, MOV0, LD0-LD4, ST0-ST4, HALT0.
- Next-state priority, highest first: reset > end_sq > state-specific rule > pause_cc > advance.
- end_sq (any state):
  - Next state is F0, or R if step_mode=1.
  - instr_cnt increments by 1, wrapping at 2^CNT_W-1 -> 0.
- R:
  - Go to F0 if start=1 or AUTO_START=1, regardless of pause_cc; otherwise stay.
  - start in any other state is ignored.
- Fetch path: F0 -> F1 -> F2 -> D0, one cycle each.
- D0 (the I register is valid from this cycle; decoder outputs are idle) dispatches on I[7:4]:
  - 0000 NOP: go to F0, or R if step_mode=1; instr_cnt increments.
  - 0001 MOV: go to MOV0.
  - 0010 LD: go to LD0.
  - 0011 ST: go to ST0.
  - 1111 HALT: go to HALT0.
  - Any other value: go to HALT0 and set illegal=1; the instruction is not counted.
- Execute chains: LDn -> LDn+1 and STn -> STn+1. MOV0, LD4 and ST4 leave only via end_sq.
- No end_sq at a terminal step (decoder fault): hold that state.
- HALT0: held until reset, even if pause_cc drops; start is ignored.
- pause_cc in any other state: hold state and counters.
- Cycle counts, clock edge to clock edge, excluding time parked in R:
  - MOV: 5 cycles (F0,F1,F2,D0,MOV0).
  - LD and ST: 9 cycles each.
  - NOP: 4 cycles.
- halted, waiting and illegal are registered or decoded from the state register only; they are never driven combinationally from inputs.

Decomposition:
- Shared header (extends the existing state definitions file):
  - group bit positions;
  - all `state_*` 12-bit constants, including new state_D0;
  - opcode constants opNOP, opMOV, opLD, opST, opHALT.
- The instruction decoder consumes the same constants; state_D0 falls to its default (idle) row.
- Sub-module: retire_counter (CNT_W-bit wrap counter with inc and sync clear).
- Next-state logic stays inline.

Test Plan:
- Reset then start pulse, with I=0x16 (MOV A,B) and decoder end_sq at MOV0 -> state sequence R0,F0,F1,F2,D0,MOV0,F0; instr_cnt=1.
- I=0x21 (LD), step_mode=1 -> sequence F0..F2,D0,LD0..LD4,R0; waiting=1; instr_cnt=1; state stays R0 until next start.
- I=0x3C (ST) with pause_cc forced high for 3 cycles at ST2 -> ST2 held 4 cycles, then ST3,ST4,F0; instr_cnt unchanged during hold.
- I=0x5A at D0 -> HALT0, illegal=1, halted=1; start pulses ignored; reset -> R0, illegal=0, instr_cnt=0.
- CNT_W=4, run 16 NOPs (I=0x00) -> instr_cnt 15 -> 0 wrap; each NOP takes 4 cycles.
- Reset asserted at LD3 -> next cycle R0; instr_cnt not incremented.
